// File: rtl/counter_b32_pkg.sv
// Shared types and constants for the 32-bit counter command sequencer.
// The command entry is packed {mode, data, len}, giving 42 bits.
package counter_b32_pkg;

    localparam logic [1:0] MODE_UP3  = 2'b00;
    localparam logic [1:0] MODE_DN1  = 2'b01;
    localparam logic [1:0] MODE_UP1  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam int unsigned CMD_W = 42;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0]  mode;
        logic [31:0] data;
        logic [7:0]  len;
    } cmd_t;

    // A zero-length command still gets one enabled cycle.
    function automatic logic [7:0] eff_len(input logic [7:0] len);
        return (len == 8'd0) ? 8'd1 : len;
    endfunction

endpackage

// File: rtl/counter_b32_seq_fifo.sv
// Synchronous FIFO for queued counter commands; flush empties it in one edge.
// DEPTH must be a power of two so the pointers wrap naturally.
module cmd_fifo_b32 #(
    parameter int unsigned WIDTH = 42,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = do_pop  ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !rst_i && !flush_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/counter_b32_seq.sv
// Command sequencer driving a downstream 32-bit counter: queues commands and
// plays each out as a registered enable window of max(len,1) cycles.
module counter_b32_seq
    import counter_b32_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        b32_clk,
    input  logic        b32_reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_mode,
    input  logic [31:0] cmd_data,
    input  logic [7:0]  cmd_len,
    input  logic        b32_abort,
    input  logic        b32_rco,
    output logic        b32_enable,
    output logic [1:0]  b32_mode,
    output logic [31:0] b32_D,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rco_count
);

    state_e      state_q, state_d;
    logic [7:0]  rem_q, rem_d;
    logic        en_q, en_d;
    logic [1:0]  mode_q, mode_d;
    logic [31:0] data_q, data_d;
    logic        done_q, done_d;
    logic [7:0]  rco_q;

    logic             fifo_full, fifo_empty;
    logic             push, pop, last;
    logic [CMD_W-1:0] wr_bits, rd_bits;
    cmd_t             head;

    assign wr_bits   = {cmd_mode, cmd_data, cmd_len};
    assign head      = cmd_t'(rd_bits);
    assign cmd_ready = ~fifo_full;
    assign push      = cmd_valid & cmd_ready & ~b32_abort;

    cmd_fifo_b32 #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (b32_clk),
        .rst_i   (b32_reset),
        .flush_i (b32_abort),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_bits),
        .rdata_o (rd_bits),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge b32_clk) begin
        if (b32_reset || b32_abort) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Completion pops the next entry in the same cycle so windows abut.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        pop     = 1'b0;
        last    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_ISSUE;
                    rem_d   = eff_len(head.len);
                end
            end
            ST_ISSUE, ST_RUN: begin
                if (rem_q > 8'd1) begin
                    rem_d   = rem_q - 8'd1;
                    state_d = ST_RUN;
                end else begin
                    last = 1'b1;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_ISSUE;
                        rem_d   = eff_len(head.len);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        en_d   = (state_d != ST_IDLE);
        mode_d = pop ? head.mode : mode_q;
        data_d = pop ? head.data : data_q;
        done_d = last;
    end

    always_ff @(posedge b32_clk) begin
        if (b32_reset) begin
            rem_q  <= '0;
            en_q   <= 1'b0;
            mode_q <= MODE_UP3;
            data_q <= '0;
            done_q <= 1'b0;
        end else if (b32_abort) begin
            rem_q  <= '0;
            en_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            en_q   <= en_d;
            mode_q <= mode_d;
            data_q <= data_d;
            done_q <= done_d;
        end
    end

    // Abort leaves the rco statistic intact; only reset clears it.
    always_ff @(posedge b32_clk) begin
        if (b32_reset) begin
            rco_q <= '0;
        end else if (b32_rco && en_q && (rco_q != 8'hFF)) begin
            rco_q <= rco_q + 8'd1;
        end
    end

    assign b32_enable = en_q;
    assign b32_mode   = mode_q;
    assign b32_D      = data_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign rco_count  = rco_q;

endmodule
